// File: rtl/simon_arbiter.sv
// simon_arbiter
//   Two-requester round-robin front end for one shared SIMON core. It grants
//   one requester at a time and latches that requester's block, key and
//   direction. It sequences the core handshake, and before a decrypt under a
//   key the core does not hold it inserts a key-expansion-only pass. Each
//   requester has a one-entry result register.
//
//   Ports
//     clk, R                 clock, synchronous active-high reset
//     req/reqDir/reqKeyChg   per-requester request level, direction (1=enc),
//                            and a "key differs from my last key" flag
//     reqBlock/reqKey        per-requester block (2N) and key (M*N)
//     ack                    one-cycle grant/capture pulse
//     valid/take/result      per-requester result register and its handshake
//     err                    sticky watchdog error
//     newData/newKey/enc_dec/readData/BLOCK/KEY   registered core controls
//     loadData/loadKey/doneData/outData           core status and result
module simon_arbiter #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int TO = 255
) (
  input  logic                    clk,
  input  logic                    R,
  input  logic [1:0]              req,
  input  logic [1:0]              reqDir,
  input  logic [1:0]              reqKeyChg,
  input  logic [1:0][2*N-1:0]     reqBlock,
  input  logic [1:0][M*N-1:0]     reqKey,
  output logic [1:0]              ack,
  output logic [1:0]              valid,
  input  logic [1:0]              take,
  output logic [1:0][2*N-1:0]     result,
  output logic                    err,
  output logic                    newData,
  output logic                    newKey,
  output logic                    enc_dec,
  output logic                    readData,
  output logic [2*N-1:0]          BLOCK,
  output logic [M*N-1:0]          KEY,
  input  logic                    loadData,
  input  logic                    loadKey,
  input  logic                    doneData,
  input  logic [2*N-1:0]          outData
);

  localparam int BW  = 2*N;
  localparam int KW  = M*N;
  localparam int WDW = ($clog2(TO+1) > 8) ? $clog2(TO+1) : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_KEY_REQ, S_KEY_WAIT, S_DATA_REQ, S_DATA_WAIT, S_READ
  } state_t;

  state_t             r_state;
  logic               r_g;          // requester being served
  logic               r_last;       // requester served last (tie-break)
  logic               r_dir;
  logic               r_keychg;
  logic               r_own_vld;    // keyOwner != NONE
  logic               r_own;        // keyOwner id when r_own_vld
  logic [WDW-1:0]     r_wd;
  logic [1:0]         r_ack;
  logic [1:0]         r_valid;
  logic [1:0][BW-1:0] r_result;
  logic               r_err;
  logic               r_newData;
  logic               r_newKey;
  logic               r_enc_dec;
  logic               r_readData;
  logic [BW-1:0]      r_block;
  logic [KW-1:0]      r_key;

  logic [1:0]         w_elig;
  logic               w_pick;
  logic               w_need;
  logic               w_wd_exp;

  // A full result register blocks its owner from being granted again.
  assign w_elig   = req & ~r_valid;
  // On a tie serve the requester that was not served last.
  assign w_pick   = (&w_elig) ? ~r_last : w_elig[1];
  // The core must (re)expand unless it already holds this requester's key.
  assign w_need   = r_keychg | ~r_own_vld | (r_own != r_g);
  assign w_wd_exp = (r_wd == WDW'(TO));

  always_ff @(posedge clk) begin
    if (R) begin
      r_state    <= S_IDLE;
      r_g        <= 1'b0;
      r_last     <= 1'b1;
      r_dir      <= 1'b0;
      r_keychg   <= 1'b0;
      r_own_vld  <= 1'b0;
      r_own      <= 1'b0;
      r_wd       <= '0;
      r_ack      <= '0;
      r_valid    <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_newData  <= 1'b0;
      r_newKey   <= 1'b0;
      r_enc_dec  <= 1'b0;
      r_readData <= 1'b0;
      r_block    <= '0;
      r_key      <= '0;
    end else begin
      r_ack <= '0;
      for (int i = 0; i < 2; i++)
        if (take[i]) r_valid[i] <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_wd <= '0;
          if (|w_elig) begin
            r_g           <= w_pick;
            r_ack[w_pick] <= 1'b1;
            r_block       <= reqBlock[w_pick];
            r_key         <= reqKey[w_pick];
            r_dir         <= reqDir[w_pick];
            r_keychg      <= reqKeyChg[w_pick];
            r_state       <= S_GRANT;
          end
        end

        S_GRANT: begin
          r_wd <= '0;
          // Decryption needs the round keys expanded before the data pass;
          // encryption can expand inline with newKey on the data pass.
          if (!r_dir && w_need) begin
            r_newKey  <= 1'b1;
            r_newData <= 1'b0;
            r_enc_dec <= 1'b0;
            r_state   <= S_KEY_REQ;
          end else begin
            r_newData <= 1'b1;
            r_newKey  <= w_need;
            r_enc_dec <= r_dir;
            r_state   <= S_DATA_REQ;
          end
        end

        default: begin
          if (w_wd_exp) begin
            // Core stopped answering: abandon the job and forget key ownership.
            r_err      <= 1'b1;
            r_newData  <= 1'b0;
            r_newKey   <= 1'b0;
            r_enc_dec  <= 1'b0;
            r_readData <= 1'b0;
            r_block    <= '0;
            r_key      <= '0;
            r_own_vld  <= 1'b0;
            r_wd       <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_wd <= r_wd + WDW'(1);
            case (r_state)
              S_KEY_REQ: if (loadKey) begin
                r_newKey <= 1'b0;
                r_wd     <= '0;
                r_state  <= S_KEY_WAIT;
              end
              S_KEY_WAIT: if (!loadKey) begin
                r_own_vld <= 1'b1;
                r_own     <= r_g;
                r_newData <= 1'b1;
                r_newKey  <= 1'b0;
                r_enc_dec <= r_dir;
                r_wd      <= '0;
                r_state   <= S_DATA_REQ;
              end
              S_DATA_REQ: if (loadData) begin
                r_newData <= 1'b0;
                r_newKey  <= 1'b0;
                if (r_newKey) begin
                  r_own_vld <= 1'b1;
                  r_own     <= r_g;
                end
                r_wd    <= '0;
                r_state <= S_DATA_WAIT;
              end
              S_DATA_WAIT: if (doneData) begin
                r_result[r_g] <= outData;
                r_valid[r_g]  <= 1'b1;
                r_readData    <= 1'b1;
                r_wd          <= '0;
                r_state       <= S_READ;
              end
              S_READ: if (!doneData) begin
                r_readData <= 1'b0;
                r_last     <= r_g;
                r_wd       <= '0;
                r_state    <= S_IDLE;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign valid    = r_valid;
  assign result   = r_result;
  assign err      = r_err;
  assign newData  = r_newData;
  assign newKey   = r_newKey;
  assign enc_dec  = r_enc_dec;
  assign readData = r_readData;
  assign BLOCK    = r_block;
  assign KEY      = r_key;

endmodule

// File: tb/tb_simon_arbiter.sv
// tb_simon_arbiter
//   Bench for simon_arbiter with a behavioural SIMON32/64 core on the core
//   side. The core model keeps the last expanded key, so a missing key load
//   gives a wrong result. It cannot expand-and-decrypt in one pass, so a
//   decrypt that skips the key-only pass under a new key gives a wrong result.
module tb_simon_arbiter;
  localparam int N  = 16;
  localparam int M  = 4;
  localparam int TO = 255;
  localparam logic [63:0] K0 = 64'h1918_1110_0908_0100;

  logic             clk = 1'b0;
  logic             R;
  logic [1:0]       req, reqDir, reqKeyChg, take, ack, valid;
  logic [1:0][31:0] reqBlock, result;
  logic [1:0][63:0] reqKey;
  logic             err, newData, newKey, enc_dec, readData;
  logic             loadData, loadKey, doneData;
  logic [31:0]      BLOCK, outData;
  logic [63:0]      KEY;

  simon_arbiter #(.N(N), .M(M), .TO(TO)) dut (
    .clk(clk), .R(R), .req(req), .reqDir(reqDir), .reqKeyChg(reqKeyChg),
    .reqBlock(reqBlock), .reqKey(reqKey), .ack(ack), .valid(valid), .take(take),
    .result(result), .err(err), .newData(newData), .newKey(newKey),
    .enc_dec(enc_dec), .readData(readData), .BLOCK(BLOCK), .KEY(KEY),
    .loadData(loadData), .loadKey(loadKey), .doneData(doneData), .outData(outData)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ---------------- SIMON32/64 reference ----------------
  function automatic logic [15:0] rol16(input logic [15:0] v, input int r);
    return (v << r) | (v >> (16 - r));
  endfunction

  function automatic logic [31:0] simon(input logic [31:0] blk, input logic [63:0] key, input logic enc);
    logic [61:0] z;
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    z = 62'b11111010_00100101_01100001_11001101_11110100_01001010_11000011_100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rol16(k[i-1], 13) ^ k[i-3];
      t = t ^ rol16(t, 15);
      k[i] = ~k[i-4] ^ t ^ {15'b0, z[61-(i-4)]} ^ 16'h0003;
    end
    x = blk[31:16];
    y = blk[15:0];
    if (enc) begin
      for (int i = 0; i < 32; i++) begin
        t = x;
        x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ k[i];
        y = t;
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        t = y;
        y = x ^ ((rol16(y, 1) & rol16(y, 8)) ^ rol16(y, 2)) ^ k[i];
        x = t;
      end
    end
    return {x, y};
  endfunction

  // ---------------- behavioural core ----------------
  int          cst, ccnt, kp_cnt = 0;
  bit          last_dnk, stall = 1'b0;
  logic        ddir;
  logic [31:0] dblk;
  logic [63:0] ckey;

  always @(negedge clk) begin
    if (R) begin
      cst = 0; ccnt = 0; ckey = '0;
      loadKey = 1'b0; loadData = 1'b0; doneData = 1'b0; outData = '0;
    end else begin
      case (cst)
        0: if (newKey && !newData) begin
             ckey = KEY; loadKey = 1'b1; ccnt = 4; cst = 1; kp_cnt++;
           end else if (newData && !stall) begin
             last_dnk = newKey;
             // an inline key load is only usable for encryption
             if (newKey) ckey = enc_dec ? KEY : ~KEY;
             dblk = BLOCK; ddir = enc_dec; loadData = 1'b1; ccnt = 5; cst = 2;
           end
        1: begin
             ccnt--;
             if (ccnt == 0) begin loadKey = 1'b0; cst = 0; end
           end
        2: begin
             ccnt--;
             if (ccnt == 3) loadData = 1'b0;
             if (ccnt == 0) begin outData = simon(dblk, ckey, ddir); doneData = 1'b1; cst = 3; end
           end
        3: if (readData) begin doneData = 1'b0; cst = 4; end
        default: if (!readData) cst = 0;
      endcase
    end
  end

  // ---------------- transaction model ----------------
  int          own = -1;            // key holder in the core, -1 = none
  logic [63:0] lastkey [2];
  bit          lk_vld [2];
  logic [63:0] cur_key [2];
  logic [31:0] cur_blk [2];
  bit          cur_dir [2], cur_kc [2];
  logic [31:0] exp_res [2];
  bit          exp_kp [2], exp_dnk [2];
  int          kp_snap [2];

  task automatic issue(input int p, input logic d, input logic [63:0] k, input logic [31:0] b);
    bit kc;
    kc = !lk_vld[p] || (k != lastkey[p]);
    lastkey[p] = k; lk_vld[p] = 1'b1;
    cur_key[p] = k; cur_blk[p] = b; cur_dir[p] = d; cur_kc[p] = kc;
    reqDir[p] = d; reqKeyChg[p] = kc; reqBlock[p] = b; reqKey[p] = k; req[p] = 1'b1;
  endtask

  task automatic on_grant(input int p);
    bit need;
    need = cur_kc[p] || (own != p);
    exp_kp[p]  = need && !cur_dir[p];
    exp_dnk[p] = need && cur_dir[p];
    if (need) own = p;
    exp_res[p] = simon(cur_blk[p], cur_key[p], cur_dir[p]);
    kp_snap[p] = kp_cnt;
    req[p] = 1'b0;
  endtask

  task automatic wait_ack(input int p, output int cyc);
    bit ok;
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      cyc++;
      ok = ack[p];
    end
    chk("ack_seen", 64'(ok), 64'(1));
  endtask

  task automatic do_take(input int p);
    take[p] = 1'b1;
    @(negedge clk);
    take[p] = 1'b0;
    chk("valid_clr", 64'(valid[p]), 64'(0));
  endtask

  task automatic finish(input int p, input bit tk);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      ok = valid[p];
    end
    chk("valid_seen", 64'(ok), 64'(1));
    chk("result", 64'(result[p]), 64'(exp_res[p]));
    chk("keypass", 64'(kp_cnt - kp_snap[p]), 64'(exp_kp[p]));
    chk("data_newkey", 64'(last_dnk), 64'(exp_dnk[p]));
    if (tk) do_take(p);
  endtask

  task automatic do_reset();
    R = 1'b1;
    req = '0; take = '0;
    repeat (3) @(negedge clk);
    own = -1;
  endtask

  task automatic one(input int p, input logic d, input logic [63:0] k, input logic [31:0] b);
    int c;
    issue(p, d, k, b);
    wait_ack(p, c);
    chk("ack_lat", 64'(c), 64'(1));
    on_grant(p);
    finish(p, 1'b1);
  endtask

  initial begin
    int c, cnt;
    bit got, saw0;
    reqDir = '0; reqKeyChg = '0; reqBlock = '0; reqKey = '0;
    lk_vld[0] = 1'b0; lk_vld[1] = 1'b0;

    // reset state
    do_reset();
    chk("rst_ctl", 64'({ack, valid, newData, newKey, enc_dec, readData, err}), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_block", 64'(BLOCK), 64'(0));
    chk("rst_key", KEY, 64'(0));
    R = 1'b0;
    @(negedge clk);

    // encrypt port 0, known vector; result held until take
    issue(0, 1'b1, K0, 32'h6565_6877);
    wait_ack(0, c);
    chk("enc_ack_lat", 64'(c), 64'(1));
    on_grant(0);
    @(negedge clk);
    chk("ack_pulse", 64'(ack), 64'(0));
    finish(0, 1'b0);
    chk("enc_vec", 64'(result[0]), 64'h0000_0000_c69b_e9bb);
    repeat (3) @(negedge clk);
    chk("valid_hold", 64'(valid[0]), 64'(1));
    do_take(0);

    // decrypt port 1 under port 0's key: key-only pass first
    one(1, 1'b0, K0, 32'hc69b_e9bb);
    chk("dec_vec", 64'(result[1]), 64'h0000_0000_6565_6877);

    // key reuse on port 0
    one(0, 1'b1, K0, 32'h6565_6877);
    one(0, 1'b1, K0, 32'h6565_6877);
    chk("reuse_vec", 64'(result[0]), 64'h0000_0000_c69b_e9bb);

    // ties after reset: port 0 first, twice
    do_reset();
    R = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      issue(0, 1'b1, {$urandom, $urandom}, $urandom);
      issue(1, 1'(t), {$urandom, $urandom}, $urandom);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        got = |ack;
      end
      chk("tie_first", 64'(ack), 64'(2'b01));
      on_grant(0);
      finish(0, 1'b1);
      wait_ack(1, c);
      on_grant(1);
      finish(1, 1'b1);
    end

    // full result register on port 0
    issue(0, 1'b1, K0, $urandom);
    wait_ack(0, c);
    on_grant(0);
    finish(0, 1'b0);
    issue(0, 1'b0, K0, $urandom);
    issue(1, 1'b1, {$urandom, $urandom}, $urandom);
    saw0 = 1'b0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      saw0 |= ack[0];
      got = ack[1];
    end
    chk("full_ack1", 64'(got), 64'(1));
    on_grant(1);
    finish(1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      saw0 |= ack[0];
    end
    chk("full_noack0", 64'(saw0), 64'(0));
    take[0] = 1'b1;
    @(negedge clk);
    take[0] = 1'b0;
    chk("full_ack0_early", 64'(ack[0]), 64'(0));
    @(negedge clk);
    chk("full_ack0_after_take", 64'(ack[0]), 64'(1));
    on_grant(0);
    finish(0, 1'b1);

    // watchdog: core never answers loadData
    one(0, 1'b1, K0, $urandom);
    stall = 1'b1;
    issue(0, 1'b1, K0, $urandom);
    wait_ack(0, c);
    on_grant(0);
    own = -1;
    cnt = 0; got = 1'b0;
    for (int i = 0; i < TO + 40 && !got; i++) begin
      @(negedge clk);
      cnt++;
      got = err;
    end
    chk("wd_err", 64'(got), 64'(1));
    chk("wd_lat_ok", 64'(cnt >= TO && cnt <= TO + 3), 64'(1));
    chk("wd_newData", 64'(newData), 64'(0));
    chk("wd_valid", 64'(valid[0]), 64'(0));
    stall = 1'b0;
    // back in IDLE with ownership dropped: fresh grant reloads the key
    one(0, 1'b1, K0, $urandom);

    // reset while waiting for the core's result
    issue(1, 1'b1, {$urandom, $urandom}, $urandom);
    wait_ack(1, c);
    on_grant(1);
    for (int i = 0; i < 100 && cst != 2; i++) @(negedge clk);
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'(1));
    R = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", 64'({ack, valid, newData, newKey, enc_dec, readData, err}), 64'(0));
    chk("midrst_result", 64'(result), 64'(0));
    chk("midrst_core", 64'(BLOCK) | KEY, 64'(0));
    @(negedge clk);
    R = 1'b0;
    own = -1;
    @(negedge clk);

    // randomized single-requester traffic
    for (int t = 0; t < 20; t++) begin
      int p;
      logic d;
      logic [63:0] k;
      p = int'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (lk_vld[p] && $urandom_range(0, 1) == 1) k = lastkey[p];
      else k = {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      one(p, d, k, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_arbiter.md
# simon_arbiter

Two-requester round-robin arbiter and sequencer for a single shared SIMON core (N=16, M=4 default, SIMON32/64). It grants one requester at a time and latches that requester's block, key and direction. It drives the core's newData/newKey/enc_dec/readData handshake, including a key-expansion-only pass before decryption under a new key. Each requester gets a one-entry result register. The block sits between the two client channels and the core's control ports.

## Interface
- N, 16: word width; blocks are 2N, keys M·N.
- M, 4: key words.
- TO, 255: watchdog limit in cycles for any wait on the core.

Ports:
- clk  in  1  system clock; all logic on posedge.
- R  in  1  reset; synchronous, active-high.
- req  in  2  per-requester request level; held until ack.
- reqDir  in  2  per-requester direction; 1=encrypt, 0=decrypt.
- reqKeyChg  in  2  per-requester flag: key differs from the last key this requester used.
- reqBlock  in  2×2×N  per-requester block.
- reqKey  in  2×M×N  per-requester key.
- ack  out  2  one-cycle grant/capture pulse.
- valid  out  2  per-requester result valid.
- take  in  2  consumer accepts result; clears valid.
- result  out  2×2×N  per-requester result register.
- err  out  1  sticky watchdog error.
- newData, newKey, enc_dec, readData  out  1 each  core handshake, registered.
- BLOCK  out  2×N  to core.
- KEY  out  M×N  to core.
- loadData, loadKey, doneData  in  1 each  core status.
- outData  in  2×N  core result.

## Operation
- States: IDLE, GRANT, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, READ.
- Eligibility: requester r is eligible when req[r]=1 and valid[r]=0.
- IDLE:
  - When any requester is eligible, pick g and go to GRANT.
  - When both are eligible, pick the requester not served last. The rr pointer resets to "last=1", so port 0 wins the first tie.
- GRANT (1 cycle):
  - ack[g]=1.
  - Latch BLOCK, KEY, dir and keyChg of g.
  - Compute needKey = keyChg | (keyOwner≠g).
  - Next state:
    - dir=0 and needKey → KEY_REQ.
    - Otherwise → DATA_REQ, with newKey=needKey.
- KEY_REQ:
  - Drive newKey=1, newData=0, enc_dec=0.
  - When loadKey=1: drop newKey, go to KEY_WAIT.
- KEY_WAIT:
  - When loadKey=0 (expansion finished): keyOwner←g, go to DATA_REQ with newKey=0.
- DATA_REQ:
  - Drive newData=1, enc_dec=dir.
  - newKey is as decided in GRANT.
  - When loadData=1: drop newData and newKey. If newKey was asserted, set keyOwner←g. Go to DATA_WAIT.
- DATA_WAIT:
  - When doneData=1: result[g]←outData, valid[g]←1, readData←1, go to READ.
- READ:
  - Hold readData=1 until doneData=0, then readData←0.
  - Update rr pointer to g and return to IDLE.
- valid[r] clears on take[r]=1. A take[r] arriving in the same cycle as a new capture for r cannot occur: r is ineligible while valid[r]=1.
- Watchdog: an 8-bit+ counter clears on every state change and increments in KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT and READ.
  - At count=TO: err←1, all core outputs←0, keyOwner←NONE, go to IDLE.
  - No valid is set on this path.
  - err clears only on R.
- keyOwner ∈ {0, 1, NONE}.

## Timing
- R=1 at posedge:
  - State IDLE.
  - ack, valid, result, newData, newKey, enc_dec, readData, BLOCK, KEY, err all 0.
  - keyOwner=NONE.
  - R mid-operation aborts with no result; the core must be reset alongside.
- Grant latency: req sampled in IDLE at edge t; ack high during cycle t+1. Requester may drop req from t+2.
- Core outputs change only at posedge and are stable for the core's negedge sampling.
- Core-side latency is set by the core, roughly 2T cycles per pass. The arbiter adds 2 cycles before DATA_REQ (IDLE→GRANT→DATA_REQ), plus 2 cycles after doneData falls (READ→IDLE→GRANT).
- Back-to-back: the next grant is earliest at the cycle after READ exits.

## Test plan
- Encrypt, port 0:
  - Stimulus: KEY=1918_1110_0908_0100, BLOCK=6565_6877, dir=1, keyChg=1.
  - Required: ack[0] pulse, single pass with newKey=newData=1, result[0]=c69b_e9bb, valid[0]=1 until take.
- Decrypt with new key, port 1:
  - Stimulus: same key, BLOCK=c69b_e9bb, dir=0, keyOwner=0.
  - Required: KEY_REQ/KEY_WAIT pass with newData=0 occurs first, then the data pass with newKey=0; result[1]=6565_6877.
- Simultaneous req after reset:
  - Required: port 0 served first, then port 1.
  - A second tie after that: port 0 served first again (pointer alternates).
- Key reuse:
  - Stimulus: port 0 encrypts twice with keyChg=0 on the second request.
  - Required: the second pass has newKey=0 and the same correct ciphertext.
- Full result register:
  - Stimulus: valid[0]=1 and take withheld while port 0 re-requests.
  - Required: no ack[0]. Port 1 is still served. ack[0] follows the cycle after take[0].
- Watchdog and reset:
  - Stimulus: hold loadData=0 in DATA_REQ.
  - Required: err=1 after TO cycles, newData=0, state IDLE.
  - Stimulus: R=1 in DATA_WAIT.
  - Required: all outputs 0 on the next edge.
